// File: rtl/limn2600_mem_arbiter.sv
// Two-port SRAM arbiter for the limn2600 core: instruction fetch (port 0,
// read-only) and data (port 1, read/write) share one single-ported SRAM.
// Round-robin on ties, write protection on the data port, bounded wait on
// SRAM ready with a timeout error, all outputs registered.
module limn2600_mem_arbiter #(
  parameter int TIMEOUT = 15
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        if_req,
  input  logic [31:0] if_addr,
  output logic        if_gnt,
  output logic        if_ack,
  output logic        if_err,
  output logic [31:0] if_rdata,
  input  logic        d_req,
  input  logic        d_we,
  input  logic [31:0] d_addr,
  input  logic [31:0] d_wdata,
  output logic        d_gnt,
  output logic        d_ack,
  output logic        d_err,
  output logic [31:0] d_rdata,
  output logic        mem_cs,
  output logic        mem_we,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  input  logic [31:0] mem_rdata,
  input  logic        mem_rdy
);

  localparam logic [1:0] IDLE  = 2'd0;
  localparam logic [1:0] ISSUE = 2'd1;
  localparam logic [1:0] WAIT  = 2'd2;
  localparam logic [1:0] RESP  = 2'd3;

  // Last WAIT count value before the access is abandoned.
  localparam logic [7:0] CNT_LAST = 8'(TIMEOUT - 1);

  logic [1:0]  state;
  logic        last_gnt;   // port id of the most recent grant
  logic        port_q;     // port id of the access in flight
  logic        we_q;       // access in flight is a write
  logic        fault_q;    // access in flight was rejected by protection
  logic [7:0]  cnt;

  logic        any_req;
  logic        pick_d;
  logic        prot_fault;
  logic        resp_done;
  logic        resp_err;
  logic [31:0] resp_rdata;

  // Arbitration and protection check, evaluated against the live requests.
  always_comb begin
    any_req    = if_req | d_req;
    pick_d     = (if_req && d_req) ? ~last_gnt : d_req;
    prot_fault = pick_d && d_we &&
                 (d_addr[31:16] != 16'h0000) && (d_addr[31:16] != 16'h00F8);
  end

  // Completion decision in WAIT: protection fault, SRAM ready, or timeout.
  always_comb begin
    resp_done  = fault_q || mem_rdy || (cnt == CNT_LAST);
    resp_err   = fault_q || !mem_rdy;
    resp_rdata = (mem_rdy && !fault_q && !we_q) ? mem_rdata : 32'h0;
  end

  // Access sequencer; pulse outputs default low and are set for one cycle.
  always_ff @(posedge clk) begin
    if (!rst) begin
      state     <= IDLE;
      last_gnt  <= 1'b1;
      port_q    <= 1'b0;
      we_q      <= 1'b0;
      fault_q   <= 1'b0;
      cnt       <= 8'h0;
      if_gnt    <= 1'b0;
      if_ack    <= 1'b0;
      if_err    <= 1'b0;
      if_rdata  <= 32'h0;
      d_gnt     <= 1'b0;
      d_ack     <= 1'b0;
      d_err     <= 1'b0;
      d_rdata   <= 32'h0;
      mem_cs    <= 1'b0;
      mem_we    <= 1'b0;
      mem_addr  <= 32'h0;
      mem_wdata <= 32'h0;
    end else begin
      if_gnt   <= 1'b0;
      d_gnt    <= 1'b0;
      if_ack   <= 1'b0;
      d_ack    <= 1'b0;
      if_err   <= 1'b0;
      d_err    <= 1'b0;
      if_rdata <= 32'h0;
      d_rdata  <= 32'h0;
      mem_cs   <= 1'b0;
      mem_we   <= 1'b0;
      case (state)
        IDLE: begin
          if (any_req) begin
            port_q    <= pick_d;
            last_gnt  <= pick_d;
            we_q      <= pick_d & d_we;
            mem_addr  <= pick_d ? d_addr : if_addr;
            mem_wdata <= pick_d ? d_wdata : 32'h0;
            cnt       <= 8'h0;
            if (prot_fault) begin
              // Rejected writes spend one cycle in WAIT and finish as if
              // the memory answered instantly, so mem_cs never rises.
              fault_q <= 1'b1;
              state   <= WAIT;
            end else begin
              fault_q <= 1'b0;
              mem_cs  <= 1'b1;
              mem_we  <= pick_d & d_we;
              if_gnt  <= ~pick_d;
              d_gnt   <= pick_d;
              state   <= ISSUE;
            end
          end
        end
        ISSUE: begin
          cnt   <= 8'h0;
          state <= WAIT;
        end
        WAIT: begin
          if (resp_done) begin
            state <= RESP;
            if (port_q) begin
              d_ack   <= 1'b1;
              d_err   <= resp_err;
              d_rdata <= resp_rdata;
            end else begin
              if_ack   <= 1'b1;
              if_err   <= resp_err;
              if_rdata <= resp_rdata;
            end
          end else begin
            cnt <= cnt + 8'h1;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_limn2600_mem_arbiter.sv
// Directed bench for limn2600_mem_arbiter with a small SRAM responder.
// Inputs change and outputs are sampled on the falling edge of clk.
module tb_limn2600_mem_arbiter;

  logic        clk;
  logic        rst;
  logic        if_req;
  logic [31:0] if_addr;
  logic        if_gnt, if_ack, if_err;
  logic [31:0] if_rdata;
  logic        d_req, d_we;
  logic [31:0] d_addr, d_wdata;
  logic        d_gnt, d_ack, d_err;
  logic [31:0] d_rdata;
  logic        mem_cs, mem_we;
  logic [31:0] mem_addr, mem_wdata;
  logic [31:0] mem_rdata;
  logic        mem_rdy;

  logic        stall;
  logic [31:0] sram [0:15];
  int          cs_count;
  int          n_assert;
  int          n_fail;
  int          cs_before;

  limn2600_mem_arbiter #(.TIMEOUT(15)) dut (
    .clk(clk), .rst(rst),
    .if_req(if_req), .if_addr(if_addr),
    .if_gnt(if_gnt), .if_ack(if_ack), .if_err(if_err), .if_rdata(if_rdata),
    .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_gnt(d_gnt), .d_ack(d_ack), .d_err(d_err), .d_rdata(d_rdata),
    .mem_cs(mem_cs), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_rdata(mem_rdata), .mem_rdy(mem_rdy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // SRAM responder: answers one cycle after sampling cs=1 unless stalled.
  always @(posedge clk) begin
    mem_rdy   <= 1'b0;
    mem_rdata <= 32'h0;
    if (mem_cs) cs_count <= cs_count + 1;
    if (mem_cs && !stall) begin
      mem_rdy <= 1'b1;
      if (mem_we) sram[mem_addr[5:2]] <= mem_wdata;
      else        mem_rdata <= sram[mem_addr[5:2]];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic cyc(input int n);
    for (int i = 0; i < n; i++) @(negedge clk);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  initial begin
    n_assert = 0; n_fail = 0; cs_count = 0;
    stall = 1'b0; mem_rdy = 1'b0; mem_rdata = 32'h0;
    for (int i = 0; i < 16; i++) sram[i] = 32'h0;
    sram[4] = 32'hDEADBEEF;
    sram[5] = 32'hCAFEF00D;
    rst = 1'b0; if_req = 1'b0; if_addr = 32'h0;
    d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;

    // Reset state
    cyc(3);
    chk("rst_if_gnt", if_gnt, 0);
    chk("rst_if_ack", if_ack, 0);
    chk("rst_d_ack", d_ack, 0);
    chk("rst_mem_cs", mem_cs, 0);
    chk("rst_mem_addr", mem_addr, 0);
    chk("rst_if_rdata", if_rdata, 0);

    // Single fetch from word 4
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h0000_0010;
    cyc(1);
    chk("f1_if_gnt", if_gnt, 1);
    chk("f1_mem_cs", mem_cs, 1);
    chk("f1_mem_addr", mem_addr, 32'h10);
    chk("f1_mem_we", mem_we, 0);
    cyc(1);
    chk("f2_mem_cs", mem_cs, 0);
    chk("f2_if_gnt", if_gnt, 0);
    chk("f2_if_ack", if_ack, 0);
    cyc(1);
    chk("f3_if_ack", if_ack, 1);
    chk("f3_if_rdata", if_rdata, 32'hDEADBEEF);
    chk("f3_if_err", if_err, 0);
    chk("f3_d_ack", d_ack, 0);
    if_req = 1'b0;
    cyc(1);
    chk("f4_if_ack", if_ack, 0);
    chk("f4_if_rdata", if_rdata, 0);
    chk("f4_cs_count", cs_count, 1);

    // Round-robin: both requesting out of reset
    rst = 1'b0;
    cyc(2);
    rst = 1'b1; if_req = 1'b1; if_addr = 32'h10; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    cyc(1);
    chk("rr1_if_gnt", if_gnt, 1);
    chk("rr1_d_gnt", d_gnt, 0);
    cyc(2);
    chk("rr1_if_ack", if_ack, 1);
    chk("rr1_if_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    cyc(1);
    if_req = 1'b1;
    cyc(1);
    chk("rr2_d_gnt", d_gnt, 1);
    chk("rr2_if_gnt", if_gnt, 0);
    chk("rr2_mem_addr", mem_addr, 32'h14);
    cyc(2);
    chk("rr2_d_ack", d_ack, 1);
    chk("rr2_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("rr2_if_ack", if_ack, 0);
    d_req = 1'b0;
    cyc(2);
    chk("rr3_if_gnt", if_gnt, 1);
    chk("rr3_d_gnt", d_gnt, 0);
    cyc(2);
    chk("rr3_if_ack", if_ack, 1);
    if_req = 1'b0;
    cyc(1);

    // Data write to the permitted window, then read back
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h00F8_0008; d_wdata = 32'h1234_5678;
    cyc(1);
    chk("w1_d_gnt", d_gnt, 1);
    chk("w1_mem_cs", mem_cs, 1);
    chk("w1_mem_we", mem_we, 1);
    chk("w1_mem_wdata", mem_wdata, 32'h1234_5678);
    cyc(2);
    chk("w1_d_ack", d_ack, 1);
    chk("w1_d_err", d_err, 0);
    chk("w1_d_rdata", d_rdata, 0);
    d_req = 1'b0;
    cyc(1);
    chk("w1_mem_we_idle", mem_we, 0);
    d_req = 1'b1; d_we = 1'b0;
    cyc(1);
    chk("r1_mem_we", mem_we, 0);
    cyc(2);
    chk("r1_d_ack", d_ack, 1);
    chk("r1_d_rdata", d_rdata, 32'h1234_5678);
    chk("r1_d_err", d_err, 0);
    d_req = 1'b0;
    cyc(1);

    // Protected write: rejected without touching the SRAM
    cs_before = cs_count;
    d_req = 1'b1; d_we = 1'b1; d_addr = 32'h0001_0000; d_wdata = 32'hFFFF_FFFF;
    cyc(1);
    chk("p1_mem_cs", mem_cs, 0);
    chk("p1_d_ack", d_ack, 0);
    cyc(1);
    chk("p2_d_ack", d_ack, 1);
    chk("p2_d_err", d_err, 1);
    chk("p2_d_rdata", d_rdata, 0);
    d_req = 1'b0;
    cyc(1);
    chk("p3_d_ack", d_ack, 0);
    chk("p3_d_err", d_err, 0);
    chk("p3_cs_count", cs_count, cs_before);

    // SRAM stalled: timeout after 15 WAIT cycles
    stall = 1'b1; if_req = 1'b1; if_addr = 32'h10;
    cyc(1);
    chk("t1_if_gnt", if_gnt, 1);
    cyc(15);
    chk("t16_if_ack", if_ack, 0);
    cyc(1);
    chk("t17_if_ack", if_ack, 1);
    chk("t17_if_err", if_err, 1);
    chk("t17_if_rdata", if_rdata, 0);
    if_req = 1'b0; stall = 1'b0;
    cyc(1);
    chk("t18_if_err", if_err, 0);
    if_req = 1'b1;
    cyc(1);
    chk("t19_if_gnt", if_gnt, 1);
    cyc(2);
    chk("t21_if_ack", if_ack, 1);
    chk("t21_if_err", if_err, 0);
    chk("t21_if_rdata", if_rdata, 32'hDEADBEEF);
    if_req = 1'b0;
    cyc(1);

    // Reset during WAIT abandons the access; held request completes later
    d_req = 1'b1; d_we = 1'b0; d_addr = 32'h14;
    cyc(1);
    chk("x1_d_gnt", d_gnt, 1);
    cyc(1);
    rst = 1'b0;
    cyc(1);
    chk("x3_d_ack", d_ack, 0);
    chk("x3_d_rdata", d_rdata, 0);
    chk("x3_mem_cs", mem_cs, 0);
    chk("x3_mem_addr", mem_addr, 0);
    chk("x3_d_gnt", d_gnt, 0);
    rst = 1'b1;
    cyc(1);
    chk("x4_d_ack", d_ack, 0);
    chk("x4_d_gnt", d_gnt, 1);
    cyc(2);
    chk("x6_d_ack", d_ack, 1);
    chk("x6_d_rdata", d_rdata, 32'hCAFEF00D);
    chk("x6_d_err", d_err, 0);
    d_req = 1'b0;
    cyc(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
